// File: rtl/seg_scan_mux.sv
// seg_scan_mux: scans a multi-nibble value one digit at a time onto a
// downstream 7-segment hex decoder. It drives active-low digit anodes that
// are aligned with the decoder's registered segment output, updates the
// displayed value only at frame boundaries, and can blank leading zeros.
module seg_scan_mux #(
    parameter int unsigned NUM_DIGITS  = 8,
    parameter int unsigned REFRESH_DIV = 4
) (
    input  logic                      slowClk,
    input  logic                      reset,
    input  logic [4*NUM_DIGITS-1:0]   value_in,
    input  logic                      load,
    input  logic                      blank_lz,
    output logic [3:0]                reg_hex,
    output logic [NUM_DIGITS-1:0]     anode,
    output logic [2:0]                digit_idx,
    output logic                      frame_done
);

    localparam int unsigned VAL_W = 4 * NUM_DIGITS;
    localparam int unsigned CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [2:0]       IDX_LAST = 3'(NUM_DIGITS - 1);

    logic [CNT_W-1:0]      cnt;
    logic [2:0]            idx;
    logic [VAL_W-1:0]      display;
    logic [VAL_W-1:0]      shadow;
    logic                  pending;
    logic                  lit_q;

    logic                  tick_c;
    logic                  frame_end_c;
    logic [3:0]            nibble_c;
    logic                  blank_c;
    logic [NUM_DIGITS-1:0] zero_from_c;
    logic [NUM_DIGITS-1:0] anode_c;

    // Hold-period tick and end-of-frame detection
    always_comb begin
        tick_c      = (cnt == CNT_LAST);
        frame_end_c = tick_c && (idx == IDX_LAST);
    end

    // zero_from_c[k]: nibbles k..NUM_DIGITS-1 of the display are all zero
    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_zero_from
        assign zero_from_c[g] = ~|display[VAL_W-1:4*g];
    end

    // Select the current digit's nibble and decide whether it is blanked
    always_comb begin
        nibble_c = 4'h0;
        blank_c  = 1'b0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx == 3'(k)) begin
                nibble_c = display[4*k +: 4];
                blank_c  = blank_lz && (k != 0) && zero_from_c[k];
            end
        end
    end

    // Anode pattern for the digit presented on reg_hex last cycle
    always_comb begin
        anode_c = '1;
        if (lit_q) begin
            for (int k = 0; k < NUM_DIGITS; k++) begin
                if (digit_idx == 3'(k)) begin
                    anode_c[k] = 1'b0;
                end
            end
        end
    end

    // Prescaler and digit index
    always_ff @(posedge slowClk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
            idx <= 3'd0;
        end else begin
            cnt <= tick_c ? '0 : cnt + CNT_W'(1);
            if (tick_c) begin
                idx <= (idx == IDX_LAST) ? 3'd0 : idx + 3'd1;
            end
        end
    end

    // Shadow capture and tear-free display update at frame end
    always_ff @(posedge slowClk or posedge reset) begin
        if (reset) begin
            display <= '0;
            shadow  <= '0;
            pending <= 1'b0;
        end else if (load && frame_end_c) begin
            display <= value_in;
            pending <= 1'b0;
        end else if (load) begin
            shadow  <= value_in;
            pending <= 1'b1;
        end else if (frame_end_c && pending) begin
            display <= shadow;
            pending <= 1'b0;
        end
    end

    // Output pipeline: nibble/index/blank stage, then anode stage
    always_ff @(posedge slowClk or posedge reset) begin
        if (reset) begin
            reg_hex    <= 4'h0;
            digit_idx  <= 3'd0;
            lit_q      <= 1'b0;
            anode      <= '1;
            frame_done <= 1'b0;
        end else begin
            reg_hex    <= nibble_c;
            digit_idx  <= idx;
            lit_q      <= ~blank_c;
            anode      <= anode_c;
            frame_done <= frame_end_c;
        end
    end

endmodule

// File: tb/tb_seg_scan_mux.sv
// Directed bench for seg_scan_mux: default 8-digit/div-4 instance plus a
// 4-digit/div-1 instance sharing clock and reset.
module tb_seg_scan_mux;

    logic        slowClk;
    logic        reset;
    logic [31:0] value_in;
    logic        load;
    logic        blank_lz;
    logic [3:0]  reg_hex;
    logic [7:0]  anode;
    logic [2:0]  digit_idx;
    logic        frame_done;

    logic [15:0] value2;
    logic        load2;
    logic        blank2;
    logic [3:0]  reg_hex2;
    logic [3:0]  anode2;
    logic [2:0]  digit_idx2;
    logic        frame_done2;

    int n_cmp;
    int n_err;

    seg_scan_mux #(.NUM_DIGITS(8), .REFRESH_DIV(4)) dut (
        .slowClk    (slowClk),
        .reset      (reset),
        .value_in   (value_in),
        .load       (load),
        .blank_lz   (blank_lz),
        .reg_hex    (reg_hex),
        .anode      (anode),
        .digit_idx  (digit_idx),
        .frame_done (frame_done)
    );

    seg_scan_mux #(.NUM_DIGITS(4), .REFRESH_DIV(1)) dut_fast (
        .slowClk    (slowClk),
        .reset      (reset),
        .value_in   (value2),
        .load       (load2),
        .blank_lz   (blank2),
        .reg_hex    (reg_hex2),
        .anode      (anode2),
        .digit_idx  (digit_idx2),
        .frame_done (frame_done2)
    );

    initial begin
        slowClk = 1'b0;
        forever #5 slowClk = ~slowClk;
    end

    // Wait (bounded) until frame_done is seen high at a falling edge
    task automatic wait_frame(input string tag);
        int n;
        n = 0;
        while (frame_done !== 1'b1 && n < 100) begin
            @(negedge slowClk);
            n++;
        end
        n_cmp++;
        if (frame_done !== 1'b1) begin
            n_err++;
            $display("FAIL %s frame_done timeout: got %b expected 1", tag, frame_done);
        end
    endtask

    // Starting at the falling edge where frame_done=1, check one whole frame
    task automatic check_frame(input logic [31:0] val, input logic [7:0] lit,
                               input int lt1, input logic [31:0] lv1,
                               input int lt2, input logic [31:0] lv2,
                               input string tag);
        int d;
        int ad;
        logic [3:0] exp_hex;
        logic [7:0] exp_an;
        for (int t = 1; t <= 32; t++) begin
            @(negedge slowClk);
            d = (t - 1) / 4;
            exp_hex = val[4*d +: 4];
            n_cmp++;
            if (reg_hex !== exp_hex) begin
                n_err++;
                $display("FAIL %s reg_hex t=%0d: got %h expected %h", tag, t, reg_hex, exp_hex);
            end
            n_cmp++;
            if (digit_idx !== 3'(d)) begin
                n_err++;
                $display("FAIL %s digit_idx t=%0d: got %0d expected %0d", tag, t, digit_idx, d);
            end
            if (t >= 2) begin
                ad = (t - 2) / 4;
                exp_an = lit[ad] ? 8'(~(8'h01 << ad)) : 8'hFF;
                n_cmp++;
                if (anode !== exp_an) begin
                    n_err++;
                    $display("FAIL %s anode t=%0d: got %h expected %h", tag, t, anode, exp_an);
                end
            end
            n_cmp++;
            if (frame_done !== (t == 32)) begin
                n_err++;
                $display("FAIL %s frame_done t=%0d: got %b expected %b", tag, t, frame_done, (t == 32));
            end
            if (t == lt1) begin
                load = 1'b1;
                value_in = lv1;
            end else if (t == lt2) begin
                load = 1'b1;
                value_in = lv2;
            end else begin
                load = 1'b0;
            end
        end
        load = 1'b0;
    endtask

    // After reset release: first tick 4 cycles later, anode one stage behind
    task automatic check_restart(input string tag);
        logic [2:0] exp_idx;
        logic [7:0] exp_an;
        for (int k = 1; k <= 6; k++) begin
            @(negedge slowClk);
            exp_idx = (k >= 5) ? 3'd1 : 3'd0;
            exp_an  = (k == 1) ? 8'hFF : ((k == 6) ? 8'hFD : 8'hFE);
            n_cmp++;
            if (digit_idx !== exp_idx) begin
                n_err++;
                $display("FAIL %s digit_idx edge %0d: got %0d expected %0d", tag, k, digit_idx, exp_idx);
            end
            n_cmp++;
            if (anode !== exp_an) begin
                n_err++;
                $display("FAIL %s anode edge %0d: got %h expected %h", tag, k, anode, exp_an);
            end
            n_cmp++;
            if (reg_hex !== 4'h0) begin
                n_err++;
                $display("FAIL %s reg_hex edge %0d: got %h expected 0", tag, k, reg_hex);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge slowClk);
        n_cmp++;
        if (anode !== 8'hFF || reg_hex !== 4'h0 || frame_done !== 1'b0 || digit_idx !== 3'd0) begin
            n_err++;
            $display("FAIL reset_state: got anode=%h hex=%h fd=%b idx=%0d expected FF/0/0/0",
                     anode, reg_hex, frame_done, digit_idx);
        end
        n_cmp++;
        if (anode2 !== 4'hF || reg_hex2 !== 4'h0 || frame_done2 !== 1'b0) begin
            n_err++;
            $display("FAIL reset_state_fast: got anode=%h hex=%h fd=%b expected F/0/0",
                     anode2, reg_hex2, frame_done2);
        end
        reset = 1'b0;
        check_restart("restart");
    endtask

    task automatic test_basic_scan();
        value_in = 32'h12345678;
        load = 1'b1;
        @(negedge slowClk);
        load = 1'b0;
        wait_frame("basic");
        check_frame(32'h12345678, 8'hFF, 0, 32'h0, 0, 32'h0, "basic");
    endtask

    task automatic test_mid_frame_load();
        check_frame(32'h12345678, 8'hFF, 13, 32'hDEADBEEF, 0, 32'h0, "midload_old");
        check_frame(32'hDEADBEEF, 8'hFF, 0, 32'h0, 0, 32'h0, "midload_new");
    endtask

    task automatic test_back_to_back();
        check_frame(32'hDEADBEEF, 8'hFF, 5, 32'h11111111, 31, 32'hCAFE0001, "b2b_old");
        check_frame(32'hCAFE0001, 8'hFF, 0, 32'h0, 0, 32'h0, "b2b_new");
        check_frame(32'hCAFE0001, 8'hFF, 5, 32'h000000A5, 0, 32'h0, "b2b_cleared");
    endtask

    task automatic test_blanking();
        blank_lz = 1'b1;
        check_frame(32'h000000A5, 8'h03, 5, 32'h00000000, 0, 32'h0, "blank_a5");
        check_frame(32'h00000000, 8'h01, 5, 32'h000000A5, 0, 32'h0, "blank_zero");
        blank_lz = 1'b0;
        check_frame(32'h000000A5, 8'hFF, 0, 32'h0, 0, 32'h0, "noblank_a5");
    endtask

    task automatic test_reset_mid();
        repeat (9) @(negedge slowClk);
        value_in = 32'h77777777;
        load = 1'b1;
        @(posedge slowClk);
        #2;
        load = 1'b0;
        reset = 1'b1;
        #1;
        n_cmp++;
        if (anode !== 8'hFF || reg_hex !== 4'h0 || frame_done !== 1'b0) begin
            n_err++;
            $display("FAIL reset_mid: got anode=%h hex=%h fd=%b expected FF/0/0", anode, reg_hex, frame_done);
        end
        @(negedge slowClk);
        reset = 1'b0;
        check_restart("restart_mid");
        wait_frame("reset_discard");
        check_frame(32'h00000000, 8'hFF, 0, 32'h0, 0, 32'h0, "reset_discard");
    endtask

    task automatic test_fast_refresh();
        int n;
        logic [15:0] v;
        logic [3:0]  exp_an;
        v = 16'h4321;
        value2 = v;
        load2 = 1'b1;
        @(negedge slowClk);
        load2 = 1'b0;
        n = 0;
        while (frame_done2 !== 1'b1 && n < 20) begin
            @(negedge slowClk);
            n++;
        end
        n_cmp++;
        if (frame_done2 !== 1'b1) begin
            n_err++;
            $display("FAIL fast frame_done timeout: got %b expected 1", frame_done2);
        end
        for (int t = 1; t <= 8; t++) begin
            @(negedge slowClk);
            n_cmp++;
            if (reg_hex2 !== v[4*((t-1)%4) +: 4] || digit_idx2 !== 3'((t-1)%4)) begin
                n_err++;
                $display("FAIL fast hex/idx t=%0d: got %h/%0d expected %h/%0d", t, reg_hex2, digit_idx2,
                         v[4*((t-1)%4) +: 4], (t-1)%4);
            end
            if (t >= 2) begin
                exp_an = 4'(~(4'h1 << ((t - 2) % 4)));
                n_cmp++;
                if (anode2 !== exp_an) begin
                    n_err++;
                    $display("FAIL fast anode t=%0d: got %h expected %h", t, anode2, exp_an);
                end
            end
            n_cmp++;
            if (frame_done2 !== ((t % 4) == 0)) begin
                n_err++;
                $display("FAIL fast frame_done t=%0d: got %b expected %b", t, frame_done2, ((t % 4) == 0));
            end
        end
    endtask

    initial begin
        n_cmp    = 0;
        n_err    = 0;
        reset    = 1'b1;
        value_in = 32'h0;
        load     = 1'b0;
        blank_lz = 1'b0;
        value2   = 16'h0;
        load2    = 1'b0;
        blank2   = 1'b0;

        test_reset();
        test_basic_scan();
        test_mid_frame_load();
        test_back_to_back();
        test_blanking();
        test_reset_mid();
        test_fast_refresh();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/seg_scan_mux.md
Name: seg_scan_mux

Overview:
- Upstream feeder for the per-digit 7-segment hex decoder on the board display path.
- Holds a multi-nibble value, usually a CPU register or PC selected for debug. Time-multiplexes it one nibble at a time onto the decoder's 4-bit hex input.
- Drives the active-low digit anodes, pipeline-aligned with the decoder's registered segment output.
- Provides tear-free frame-boundary updates and optional leading-zero blanking.

Parameters:
NUM_DIGITS, 8, digits scanned; legal range 1..8.
REFRESH_DIV, 4, slowClk cycles each digit is held; must be >= 1.

Ports:
slowClk  in  1  clock
reset  in  1  asynchronous, active-high reset
value_in  in  4*NUM_DIGITS  value to display; nibble k goes to digit k, digit 0 rightmost
load  in  1  capture strobe for value_in, sampled on slowClk
blank_lz  in  1  enable leading-zero blanking
reg_hex  out  4  nibble to downstream decoder, registered
anode  out  NUM_DIGITS  one-hot active-low digit enable, registered
digit_idx  out  3  index of digit currently presented on reg_hex
frame_done  out  1  one-cycle pulse when the last digit's hold period ends

Behaviour:
- Reset, async, active-high, all domains:
  - prescaler cnt=0, idx=0, display=0, shadow=0, pending=0
  - reg_hex=0, digit_idx=0, anode=all ones (all digits off), frame_done=0
  - 2-stage anode pipeline cleared to "off"
- Prescaler:
  - cnt counts 0..REFRESH_DIV-1, then wraps to 0.
  - tick = (cnt==REFRESH_DIV-1). With REFRESH_DIV=1, tick is asserted every cycle.
- Digit index:
  - On tick, idx increments.
  - At NUM_DIGITS-1, idx wraps to 0 and frame_done=1 for exactly that cycle (registered, visible the cycle after the tick edge).
- Load / update:
  - load=1 at an edge: shadow<=value_in, pending<=1.
  - At frame end (tick with idx==NUM_DIGITS-1), if pending: display<=shadow, pending<=0.
  - load coincident with frame end: display<=value_in directly, pending<=0 (newest wins).
  - display never changes mid-frame.
  - Multiple loads in one frame: last one wins.
- Output pipeline, all registered on slowClk:
  - Edge E0: idx changes.
  - Edge E1: reg_hex<=display[4*idx+:4], digit_idx<=idx.
  - Edge E2: anode<=~(1<<digit_idx), or all ones if that digit is blanked. This aligns with the decoder's own one-cycle registered outSeg.
- Blanking:
  - Digit k (k>0) is blanked when blank_lz=1 and nibbles k..NUM_DIGITS-1 of display are all zero.
  - Digit 0 is never blanked, so value 0 shows a single "0".
  - The blank decision is evaluated on the same cycle reg_hex is loaded and carried one stage with the index.
  - When blanked, reg_hex still carries the nibble (0).
- Other rules:
  - blank_lz changes take effect on the next digit presented; no frame-boundary deferral.
  - Reset mid-frame aborts the scan immediately; pending updates are discarded.
  - The scan restarts at digit 0 after reset deasserts, with display=0.
  - Index arithmetic is modulo NUM_DIGITS. Unused upper digit_idx bits are 0.

Test Plan:
- Reset values: assert reset mid-count -> same cycle anode=8'hFF, reg_hex=0, frame_done=0. After release, the first tick occurs 4 cycles later (REFRESH_DIV=4).
- Basic scan: load 0x12345678, wait one frame (32 cycles) -> reg_hex sequence 8,7,6,5,4,3,2,1, each held 4 cycles. anode follows one cycle behind: FE,FD,FB,F7,EF,DF,BF,7F. frame_done pulses every 32 cycles.
- Mid-frame load: displaying 0x12345678, load 0xDEADBEEF at digit 3 -> remaining digits still show 4,3,2,1. The next frame shows F,E,E,B,D,A,E,D.
- Simultaneous load and frame end: load 0xCAFE0001 on the last digit's tick edge while pending holds 0x11111111 -> next frame shows 0xCAFE0001 and pending is cleared.
- Leading-zero blanking: blank_lz=1, value 0x000000A5 -> anode active only for digits 0,1. Digits 2..7 give anode=FF while reg_hex=0. With value 0, only digit 0 is lit. With blank_lz=0, all 8 digits are lit.
- REFRESH_DIV=1, NUM_DIGITS=4 -> digit changes every cycle, frame_done every 4 cycles. Anode lags reg_hex by exactly one cycle.
